// File: rtl/cnt_player_multi.sv
// Position and lap tracker for NUM_PLAYERS players on a circular board.
// Holds every player's position and laps, arbitrates turns and detects the winner.
module cnt_player_multi #(
   parameter int NUM_PLAYERS = 2,
   parameter int BOARD_LEN   = 24,
   parameter int POS_W       = 5,
   parameter int STEP_W      = 3,
   parameter int LAPS_TO_WIN = 1,
   parameter int LAP_W       = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         new_game,
   input  logic                         btn,
   input  logic                         move_ok,
   input  logic [STEP_W-1:0]            step_in,
   output logic [NUM_PLAYERS*POS_W-1:0] pos_bus,
   output logic [NUM_PLAYERS*LAP_W-1:0] lap_bus,
   output logic [1:0]                   cur_player,
   output logic                         move_done,
   output logic                         game_over,
   output logic [1:0]                   winner
);

   localparam logic [POS_W:0]   BOARD_LEN_W = (POS_W+1)'(BOARD_LEN);
   localparam logic [LAP_W-1:0] LAP_WIN     = LAP_W'(LAPS_TO_WIN);
   localparam logic [LAP_W-1:0] LAP_MAX     = {LAP_W{1'b1}};
   localparam logic [1:0]       LAST_PLAYER = 2'(NUM_PLAYERS - 1);

   typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

   state_t            state;
   logic              btn_q;
   logic              press;
   logic [POS_W-1:0]  cur_pos;
   logic [LAP_W-1:0]  cur_lap;
   logic [POS_W:0]    sum;
   logic [POS_W:0]    wrapped;
   logic              wrap;
   logic [POS_W-1:0]  new_pos;
   logic [LAP_W-1:0]  lap_inc;
   logic [LAP_W-1:0]  new_lap;
   logic              win;
   logic [1:0]        next_player;

   // Move arithmetic for the player holding the turn; single subtract suffices
   // because one step is always shorter than a lap.
   always_comb begin
      press       = btn & ~btn_q;
      cur_pos     = pos_bus[cur_player*POS_W +: POS_W];
      cur_lap     = lap_bus[cur_player*LAP_W +: LAP_W];
      sum         = {1'b0, cur_pos} + {{(POS_W+1-STEP_W){1'b0}}, step_in};
      wrap        = (sum >= BOARD_LEN_W);
      wrapped     = sum - BOARD_LEN_W;
      new_pos     = wrap ? wrapped[POS_W-1:0] : sum[POS_W-1:0];
      lap_inc     = cur_lap + 1'b1;
      new_lap     = (wrap && (cur_lap != LAP_MAX)) ? lap_inc : cur_lap;
      win         = wrap && (cur_lap != LAP_MAX) && (lap_inc == LAP_WIN);
      next_player = (cur_player == LAST_PLAYER) ? 2'd0 : cur_player + 2'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         btn_q      <= 1'b0;
         pos_bus    <= '0;
         lap_bus    <= '0;
         cur_player <= 2'd0;
         move_done  <= 1'b0;
         game_over  <= 1'b0;
         winner     <= 2'd0;
      end else begin
         btn_q     <= btn;
         move_done <= 1'b0;
         if (new_game) begin
            state      <= PLAY;
            pos_bus    <= '0;
            lap_bus    <= '0;
            cur_player <= 2'd0;
            game_over  <= 1'b0;
            winner     <= 2'd0;
         end else if (state == PLAY && press) begin
            move_done <= 1'b1;
            if (move_ok) begin
               pos_bus[cur_player*POS_W +: POS_W] <= new_pos;
               lap_bus[cur_player*LAP_W +: LAP_W] <= new_lap;
               if (win) begin
                  state     <= OVER;
                  game_over <= 1'b1;
                  winner    <= cur_player;
               end
            end else begin
               cur_player <= next_player;
            end
         end
      end
   end

endmodule

// File: tb/tb_cnt_player_multi.sv
// Bench for cnt_player_multi with three players: a modulo-arithmetic game model
// checked every cycle, plus literal expectations at key points of a scripted game.
module tb_cnt_player_multi;

   localparam int NP = 3;
   localparam int BL = 24;
   localparam int PW = 5;
   localparam int SW = 3;
   localparam int LW = 2;
   localparam int LTW = 1;

   logic              clk = 1'b0;
   logic              rst;
   logic              new_game;
   logic              btn;
   logic              move_ok;
   logic [SW-1:0]     step_in;
   logic [NP*PW-1:0]  pos_bus;
   logic [NP*LW-1:0]  lap_bus;
   logic [1:0]        cur_player;
   logic              move_done;
   logic              game_over;
   logic [1:0]        winner;

   int checks = 0;
   int failures = 0;
   bit compare_on = 1'b0;

   cnt_player_multi #(
      .NUM_PLAYERS(NP), .BOARD_LEN(BL), .POS_W(PW),
      .STEP_W(SW), .LAPS_TO_WIN(LTW), .LAP_W(LW)
   ) dut (
      .clk(clk), .rst(rst), .new_game(new_game), .btn(btn),
      .move_ok(move_ok), .step_in(step_in), .pos_bus(pos_bus),
      .lap_bus(lap_bus), .cur_player(cur_player), .move_done(move_done),
      .game_over(game_over), .winner(winner)
   );

   always #5 clk = ~clk;

   // Game model: positions modulo the board length, laps counted on overflow.
   int  m_pos [NP];
   int  m_lap [NP];
   int  m_cur, m_win;
   bit  m_play, m_over, m_done, m_btn_prev;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NP; i++) begin m_pos[i] = 0; m_lap[i] = 0; end
         m_cur = 0; m_win = 0; m_play = 0; m_over = 0; m_done = 0; m_btn_prev = 0;
      end else begin
         bit pressed;
         int total;
         pressed    = btn && !m_btn_prev;
         m_btn_prev = btn;
         m_done     = 0;
         if (new_game) begin
            for (int i = 0; i < NP; i++) begin m_pos[i] = 0; m_lap[i] = 0; end
            m_cur = 0; m_win = 0; m_play = 1; m_over = 0;
         end else if (m_play && pressed) begin
            m_done = 1;
            if (move_ok) begin
               total = m_pos[m_cur] + int'(step_in);
               m_pos[m_cur] = total % BL;
               if (total >= BL && m_lap[m_cur] < (1 << LW) - 1) begin
                  m_lap[m_cur] = m_lap[m_cur] + 1;
                  if (m_lap[m_cur] == LTW) begin
                     m_play = 0; m_over = 1; m_win = m_cur;
                  end
               end
            end else begin
               m_cur = (m_cur + 1) % NP;
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (compare_on) begin
         logic [NP*PW-1:0] exp_pos;
         logic [NP*LW-1:0] exp_lap;
         exp_pos = '0;
         exp_lap = '0;
         for (int i = 0; i < NP; i++) begin
            exp_pos[i*PW +: PW] = PW'(m_pos[i]);
            exp_lap[i*LW +: LW] = LW'(m_lap[i]);
         end
         check("model_pos_bus",    32'(pos_bus),    32'(exp_pos));
         check("model_lap_bus",    32'(lap_bus),    32'(exp_lap));
         check("model_cur_player", 32'(cur_player), 32'(m_cur));
         check("model_move_done",  32'(move_done),  32'(m_done));
         check("model_game_over",  32'(game_over),  32'(m_over));
         check("model_winner",     32'(winner),     32'(m_win));
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic press(input logic ok, input logic [SW-1:0] step);
      btn = 1'b1; move_ok = ok; step_in = step;
      tick();
      btn = 1'b0;
      tick();
   endtask

   int done_cnt;

   initial begin
      rst = 1'b1; new_game = 1'b0; btn = 1'b0; move_ok = 1'b0; step_in = '0;
      #12;
      rst = 1'b0;
      compare_on = 1'b1;
      check("reset_pos", 32'(pos_bus), 32'd0);
      check("reset_over", 32'(game_over), 32'd0);

      // IDLE ignores presses
      press(1'b1, 3'd3);
      check("idle_press_ignored", 32'(pos_bus), 32'd0);

      new_game = 1'b1; tick(); new_game = 1'b0;
      check("new_game_cur", 32'(cur_player), 32'd0);
      check("new_game_lap", 32'(lap_bus), 32'd0);

      // Held button counts as one press
      btn = 1'b1; move_ok = 1'b1; step_in = 3'd3; done_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (move_done) done_cnt++;
      end
      #2 btn = 1'b0;
      tick();
      check("held_btn_pulses", 32'(done_cnt), 32'd1);
      check("held_btn_pos", 32'(pos_bus), 32'd3);

      // Misses rotate the turn through all three players
      press(1'b0, 3'd5);
      check("miss1_cur", 32'(cur_player), 32'd1);
      press(1'b1, 3'd4);
      check("p1_move_pos", 32'(pos_bus), 32'(4 << PW | 3));
      press(1'b0, 3'd5);
      check("miss2_cur", 32'(cur_player), 32'd2);
      press(1'b0, 3'd5);
      check("miss3_cur", 32'(cur_player), 32'd0);
      check("miss_pos_hold", 32'(pos_bus), 32'(4 << PW | 3));

      // Zero step and a run to position 22, then the winning lap wrap
      press(1'b1, 3'd0);
      press(1'b1, 3'd7);
      press(1'b1, 3'd7);
      press(1'b1, 3'd5);
      check("pos0_22", 32'(pos_bus[PW-1:0]), 32'd22);
      press(1'b1, 3'd5);
      check("win_pos0", 32'(pos_bus[PW-1:0]), 32'd3);
      check("win_lap0", 32'(lap_bus[LW-1:0]), 32'd1);
      check("win_over", 32'(game_over), 32'd1);
      check("win_winner", 32'(winner), 32'd0);
      press(1'b1, 3'd6);
      press(1'b0, 3'd6);
      check("over_frozen", 32'(pos_bus), 32'(4 << PW | 3));

      // new_game wins over a simultaneous press
      btn = 1'b1; move_ok = 1'b1; step_in = 3'd3; new_game = 1'b1;
      tick();
      new_game = 1'b0;
      tick();
      btn = 1'b0;
      check("ng_priority_pos", 32'(pos_bus), 32'd0);
      check("ng_priority_over", 32'(game_over), 32'd0);
      tick();

      // Asynchronous reset mid-game
      press(1'b1, 3'd6);
      check("pre_rst_pos", 32'(pos_bus), 32'd6);
      @(posedge clk); #3;
      rst = 1'b1;
      #1;
      check("async_rst_pos", 32'(pos_bus), 32'd0);
      check("async_rst_done", 32'(move_done), 32'd0);
      #3 rst = 1'b0;
      tick();
      press(1'b1, 3'd2);
      check("post_rst_ignored", 32'(pos_bus), 32'd0);
      new_game = 1'b1; tick(); new_game = 1'b0;
      press(1'b1, 3'd2);
      check("post_ng_move", 32'(pos_bus), 32'd2);
      tick();

      compare_on = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
